// File: rtl/ledr_arb_pkg.sv
// Shared types and constants for the red-LED PIO write arbiter.
package ledr_arb_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam int         PIO_DATA_W    = 32;
  localparam int         LED_W_DEF     = 18;
  localparam int         GAP_CNT_W     = 8;
endpackage

// File: rtl/ledr_write_arbiter_rr.sv
// Combinational round-robin picker; the last-grant pointer is owned by the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk from last_grant+1 around the ring; first requester seen wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = wrap_idx(last_grant, k);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ledr_write_arbiter.sv
// Serialises masked LED updates from several requesters into single-cycle PIO writes.
module ledr_write_arbiter
  import ledr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = LED_W_DEF,
  parameter int MIN_GAP = 0,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*DATA_W-1:0] req_mask,
  output logic [1:0]                pio_address,
  output logic                      pio_chipselect,
  output logic                      pio_write_n,
  output logic [PIO_DATA_W-1:0]     pio_writedata,
  output logic [DATA_W-1:0]         led_shadow,
  output logic                      busy
);

  state_t                          state, state_nxt;
  logic [IDX_W-1:0]                last_grant, grant_idx;
  logic [NUM_REQ-1:0]              grant;
  logic [GAP_CNT_W-1:0]            gap_cnt;
  logic [NUM_REQ-1:0][DATA_W-1:0]  data_v, mask_v;
  logic [DATA_W-1:0]               merged;

  assign data_v = req_data;
  assign mask_v = req_mask;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = (state == IDLE) ? grant : '0;
  assign busy      = (state != IDLE);
  assign merged    = (led_shadow & ~mask_v[grant_idx]) | (data_v[grant_idx] & mask_v[grant_idx]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|grant) state_nxt = WRITE;
      WRITE:   state_nxt = (MIN_GAP > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The strobe is registered on the grant edge, so chipselect is high exactly while in WRITE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_grant     <= IDX_W'(NUM_REQ - 1);
      gap_cnt        <= '0;
      led_shadow     <= '0;
      pio_address    <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (|grant) begin
          last_grant     <= grant_idx;
          pio_address    <= PIO_ADDR_DATA;
          pio_writedata  <= {{(PIO_DATA_W-DATA_W){1'b0}}, merged};
          pio_chipselect <= 1'b1;
          pio_write_n    <= 1'b0;
        end
        WRITE: begin
          led_shadow     <= pio_writedata[DATA_W-1:0];
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
          gap_cnt        <= GAP_CNT_W'(MIN_GAP - 1);
        end
        GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ledr_write_arbiter.sv
// Directed bench: one instance with no gap, one with MIN_GAP=3.
module tb_ledr_write_arbiter;
  localparam int N = 4;
  localparam int W = 18;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [N-1:0]        a_valid, a_ready, b_valid, b_ready;
  logic [N-1:0][W-1:0] a_data, a_mask, b_data, b_mask;
  logic [1:0]          a_addr, b_addr;
  logic                a_cs, a_wn, a_busy, b_cs, b_wn, b_busy;
  logic [31:0]         a_wd, b_wd;
  logic [W-1:0]        a_shadow, b_shadow;

  int vectors = 0;
  int miscompares = 0;

  ledr_write_arbiter #(.NUM_REQ(N), .DATA_W(W), .MIN_GAP(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(a_valid), .req_ready(a_ready),
    .req_data(a_data), .req_mask(a_mask), .pio_address(a_addr),
    .pio_chipselect(a_cs), .pio_write_n(a_wn), .pio_writedata(a_wd),
    .led_shadow(a_shadow), .busy(a_busy));

  ledr_write_arbiter #(.NUM_REQ(N), .DATA_W(W), .MIN_GAP(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_data(b_data), .req_mask(b_mask), .pio_address(b_addr),
    .pio_chipselect(b_cs), .pio_write_n(b_wn), .pio_writedata(b_wd),
    .led_shadow(b_shadow), .busy(b_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] order [8];
    order = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    reset_n = 1'b0;
    a_valid = '0; a_data = '0; a_mask = '0;
    b_valid = '0; b_data = '0; b_mask = '0;
    #12;
    chk("rst_ready",  32'(a_ready),  32'h0);
    chk("rst_cs",     32'(a_cs),     32'h0);
    chk("rst_wn",     32'(a_wn),     32'h1);
    chk("rst_addr",   32'(a_addr),   32'h0);
    chk("rst_wd",     a_wd,          32'h0);
    chk("rst_shadow", 32'(a_shadow), 32'h0);
    chk("rst_busy",   32'(a_busy),   32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // single request from req0
    a_data[0] = 18'h3FFFF; a_mask[0] = 18'h000FF; a_valid = 4'b0001;
    #1 chk("s1_ready", 32'(a_ready), 32'h1);
    step();
    a_valid = '0;
    chk("s1_cs",   32'(a_cs),   32'h1);
    chk("s1_wn",   32'(a_wn),   32'h0);
    chk("s1_wd",   a_wd,        32'h000000FF);
    chk("s1_busy", 32'(a_busy), 32'h1);
    step();
    chk("s1_shadow", 32'(a_shadow), 32'h000FF);
    chk("s1_cs_off", 32'(a_cs),     32'h0);
    chk("s1_wd_hold", a_wd,         32'h000000FF);

    // masked merge from req2
    a_data[2] = 18'h3FF00; a_mask[2] = 18'h3FF00; a_valid = 4'b0100;
    #1 chk("s2_ready", 32'(a_ready), 32'h4);
    step();
    a_valid = '0;
    chk("s2_wd", a_wd, 32'h0003FFFF);
    step();
    chk("s2_shadow", 32'(a_shadow), 32'h3FFFF);

    // all four valid continuously, rotation continues after last grant (2)
    for (int i = 0; i < N; i++) begin
      a_data[i] = 18'h00A00 + 18'(i);
      a_mask[i] = 18'h3FFFF;
    end
    a_valid = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      #1;
      chk($sformatf("rr_ready%0d", g), 32'(a_ready), 32'(4'b0001 << order[g]));
      chk($sformatf("rr_idle_cs%0d", g), 32'(a_cs), 32'h0);
      step();
      chk($sformatf("rr_wd%0d", g), a_wd, 32'h00000A00 + 32'(order[g]));
      chk($sformatf("rr_cs%0d", g), 32'(a_cs), 32'h1);
      step();
    end
    a_valid = '0;
    chk("rr_shadow", 32'(a_shadow), 32'h00A02);

    // MIN_GAP=3: req1 and req3 valid, strobes 5 cycles apart
    b_mask[0] = 18'h3FFFF; b_mask[1] = 18'h3FFFF; b_mask[2] = 18'h3FFFF; b_mask[3] = 18'h3FFFF;
    b_data[1] = 18'h11111; b_data[2] = 18'h22222; b_data[3] = 18'h33333;
    b_valid = 4'b1010;
    #1 chk("g_ready1", 32'(b_ready), 32'h2);
    step();
    chk("g_cs1", 32'(b_cs), 32'h1);
    chk("g_wd1", b_wd, 32'h00011111);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("g_gap_ready%0d", c), 32'(b_ready), 32'h0);
      chk($sformatf("g_gap_busy%0d", c), 32'(b_busy), 32'h1);
      chk($sformatf("g_gap_cs%0d", c), 32'(b_cs), 32'h0);
    end
    step();
    chk("g_ready3", 32'(b_ready), 32'h8);
    chk("g_idle_busy", 32'(b_busy), 32'h0);
    step();
    chk("g_cs3", 32'(b_cs), 32'h1);
    chk("g_wd3", b_wd, 32'h00033333);
    step();
    chk("g_shadow3", 32'(b_shadow), 32'h33333);
    // req1 withdraws during the gap; req2 is next in ring order
    b_valid = 4'b1100;
    step(); step();
    chk("w_gap_ready", 32'(b_ready), 32'h0);
    step();
    chk("w_ready2", 32'(b_ready), 32'h4);
    step();
    b_valid = '0;
    chk("w_wd2", b_wd, 32'h00022222);
    step();
    chk("w_shadow2", 32'(b_shadow), 32'h22222);

    // reset asserted during a WRITE
    a_valid = 4'b1000;
    #1 chk("r_ready3", 32'(a_ready), 32'h8);
    step();
    a_valid = '0;
    chk("r_cs_pre", 32'(a_cs), 32'h1);
    chk("r_wd_pre", a_wd, 32'h00000A03);
    reset_n = 1'b0;
    #1;
    chk("r_cs",     32'(a_cs),     32'h0);
    chk("r_wn",     32'(a_wn),     32'h1);
    chk("r_shadow", 32'(a_shadow), 32'h0);
    chk("r_busy",   32'(a_busy),   32'h0);
    #1 reset_n = 1'b1;
    a_valid = 4'b1111;
    #1 chk("r_first_ready", 32'(a_ready), 32'h1);
    step();
    a_valid = '0;
    chk("r_first_wd", a_wd, 32'h00000A00);
    step();
    chk("r_first_shadow", 32'(a_shadow), 32'h00A00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
